muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit that sits directly downstream of `register_file`. It consumes the `rs1_data`/`rs2_data` operand pair and returns a result plus destination address for the register write-back path. It stalls the core through `busy` while a MUL*/DIV*/REM* instruction is computed, one bit per cycle.

---
 rtl/muldiv_unit_pkg.sv | 44 ++++
 rtl/muldiv_unit_sign_fix.sv | 13 +
 rtl/muldiv_unit.sv | 216 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared widths, operation encoding and operand-signedness helpers for the multiply/divide unit.
package muldiv_unit_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned MULDIV_CYCLES  = XLEN;
    localparam int unsigned CNT_WIDTH      = $clog2(MULDIV_CYCLES);

    // funct3 encoding of the M extension
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    // Multiplies occupy the lower half of the funct3 space
    function automatic logic op_is_mul(input muldiv_op_e op);
        logic [2:0] v;
        v = op;
        return !v[2];
    endfunction

    // REM/REMU return the remainder rather than the quotient
    function automatic logic op_is_rem(input muldiv_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is treated as two's complement
    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as two's complement
    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// Conditional two's-complement negate: used for operand magnitudes and the final sign fix-up.
module muldiv_unit_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] value_fixed_c
);

    // Negate when requested, pass through otherwise
    assign value_fixed_c = negate ? W'(~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  muldiv_op_e                op,
    input  logic [XLEN-1:0]           operand_a,
    input  logic [XLEN-1:0]           operand_b,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_in,
    input  logic                      flush,
    output logic                      busy,
    output logic                      done,
    output logic [XLEN-1:0]           result,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                    state_q;
    state_e                    state_d;

    logic [CNT_WIDTH-1:0]      count_q;
    logic [XLEN-1:0]           acc_hi_q;
    logic [XLEN-1:0]           acc_lo_q;
    logic [XLEN-1:0]           mop_q;
    logic                      neg_q;
    muldiv_op_e                op_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;

    logic                      accept_c;
    logic                      is_div_c;
    logic                      div_zero_c;
    logic                      overflow_c;
    logic                      special_c;
    logic                      a_neg_c;
    logic                      b_neg_c;
    logic [XLEN-1:0]           abs_a_c;
    logic [XLEN-1:0]           abs_b_c;

    logic [XLEN:0]             mul_sum_c;
    logic [XLEN:0]             div_shift_c;
    logic [XLEN:0]             div_diff_c;
    logic [XLEN-1:0]           step_hi_c;
    logic [XLEN-1:0]           step_lo_c;

    logic [2*XLEN-1:0]         fix_in_c;
    logic [2*XLEN-1:0]         fixed_c;
    logic [XLEN-1:0]           final_c;

    logic                      busy_d;
    logic                      done_d;
    logic [XLEN-1:0]           result_d;
    logic [REG_ADDR_WIDTH-1:0] rd_d;

    // A request is taken only once the unit is fully idle, including the done-pulse cycle
    assign accept_c   = start && !flush && (state_q == S_IDLE) && !busy;

    // Acceptance-time classification of the incoming operation
    assign is_div_c   = !op_is_mul(op);
    assign div_zero_c = (operand_b == '0);
    assign overflow_c = ((op == OP_DIV) || (op == OP_REM)) &&
                        (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    assign special_c  = is_div_c && (div_zero_c || overflow_c);
    assign a_neg_c    = op_a_signed(op) && operand_a[XLEN-1];
    assign b_neg_c    = op_b_signed(op) && operand_b[XLEN-1];

    muldiv_unit_sign_fix #(.W(XLEN)) u_abs_a (
        .value         (operand_a),
        .negate        (a_neg_c),
        .value_fixed_c (abs_a_c)
    );

    muldiv_unit_sign_fix #(.W(XLEN)) u_abs_b (
        .value         (operand_b),
        .negate        (b_neg_c),
        .value_fixed_c (abs_b_c)
    );

    // One radix-2 iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum_c   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mop_q} : '0);
        div_shift_c = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_diff_c  = div_shift_c - {1'b0, mop_q};
        step_hi_c   = acc_hi_q;
        step_lo_c   = acc_lo_q;
        if (op_is_mul(op_q)) begin
            step_hi_c = mul_sum_c[XLEN:1];
            step_lo_c = {mul_sum_c[0], acc_lo_q[XLEN-1:1]};
        end else begin
            step_hi_c = div_diff_c[XLEN] ? div_shift_c[XLEN-1:0] : div_diff_c[XLEN-1:0];
            step_lo_c = {acc_lo_q[XLEN-2:0], !div_diff_c[XLEN]};
        end
    end

    // Select the raw magnitude to be sign-corrected: full product, quotient or remainder
    always_comb begin
        fix_in_c = {acc_hi_q, acc_lo_q};
        if (!op_is_mul(op_q)) begin
            fix_in_c = {XLEN'(0), (op_is_rem(op_q) ? acc_hi_q : acc_lo_q)};
        end
    end

    muldiv_unit_sign_fix #(.W(2*XLEN)) u_fix_result (
        .value         (fix_in_c),
        .negate        (neg_q),
        .value_fixed_c (fixed_c)
    );

    // MUL and all divides return the low word, the MULH family the high word
    always_comb begin
        final_c = fixed_c[XLEN-1:0];
        if (op_is_mul(op_q) && (op_q != OP_MUL)) begin
            final_c = fixed_c[2*XLEN-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (accept_c) state_d = special_c ? S_DONE : S_CALC;
                S_CALC: if (count_q == '0) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output next values: the DONE state is published one edge later, busy covers that extra cycle
    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result;
        rd_d     = rd_addr_out;
        if (!flush) begin
            busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
            if (state_q == S_DONE) begin
                done_d   = 1'b1;
                result_d = final_c;
                rd_d     = rd_q;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            rd_addr_out <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            result      <= result_d;
            rd_addr_out <= rd_d;
        end
    end

    // Operand capture at acceptance and per-cycle iteration in CALC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mop_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= OP_MUL;
            rd_q     <= '0;
        end else if (accept_c) begin
            op_q    <= op;
            rd_q    <= rd_addr_in;
            count_q <= CNT_WIDTH'(MULDIV_CYCLES - 1);
            if (special_c) begin
                // Quotient in the low word, remainder in the high word, no sign fix-up
                neg_q    <= 1'b0;
                mop_q    <= '0;
                acc_lo_q <= div_zero_c ? '1 : operand_a;
                acc_hi_q <= div_zero_c ? operand_a : '0;
            end else if (!is_div_c) begin
                neg_q    <= a_neg_c ^ b_neg_c;
                mop_q    <= abs_a_c;
                acc_lo_q <= abs_b_c;
                acc_hi_q <= '0;
            end else begin
                neg_q    <= op_is_rem(op) ? a_neg_c : (a_neg_c ^ b_neg_c);
                mop_q    <= abs_b_c;
                acc_lo_q <= abs_a_c;
                acc_hi_q <= '0;
            end
        end else if ((state_q == S_CALC) && !flush) begin
            count_q  <= count_q - CNT_WIDTH'(1);
            acc_hi_q <= step_hi_c;
            acc_lo_q <= step_lo_c;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with a queue-based scoreboard checked by an independent monitor.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic                      clk;
    logic                      rst_n;
    logic                      start;
    muldiv_op_e                op;
    logic [XLEN-1:0]           operand_a;
    logic [XLEN-1:0]           operand_b;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_in;
    logic                      flush;
    logic                      busy;
    logic                      done;
    logic [XLEN-1:0]           result;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          t0;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    int          cyc;
    bit          prev_done;
    logic [31:0] last_result;
    logic [4:0]  last_rd;

    muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .rd_addr_in  (rd_addr_in),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .rd_addr_out (rd_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT signals done
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_pulse_width", 32'(prev_done), 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_result"}, result, e.res);
                chk({e.name, "_rd"}, 32'(rd_addr_out), 32'(e.rd));
                chk({e.name, "_latency"}, 32'(cyc - e.t0), 32'(e.lat));
            end
        end
        prev_done = rst_n && done;
    end

    // Issue one operation; optionally poke start or assert flush on a given busy cycle
    task automatic issue(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit special,
                         input int poke_at, input int flush_at, input string name);
        int   n;
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        op         = o;
        operand_a  = a;
        operand_b  = b;
        rd_addr_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_accepted"}, 32'(busy), 32'd1);
        if (flush_at == 0) begin
            e.res  = exp;
            e.rd   = rd;
            e.t0   = cyc;
            e.lat  = special ? 1 : 33;
            e.name = name;
            sb_q.push_back(e);
        end
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            n++;
            if (n == poke_at) begin
                start      = 1'b1;
                op         = OP_MUL;
                operand_a  = 32'd3;
                operand_b  = 32'd3;
                rd_addr_in = 5'd9;
            end else begin
                start = 1'b0;
            end
            flush = (n == flush_at);
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        if (flush_at != 0) begin
            chk({name, "_busy_cycles"}, 32'(n), 32'(flush_at));
            chk({name, "_result_kept"}, result, last_result);
            chk({name, "_rd_kept"}, 32'(rd_addr_out), 32'(last_rd));
        end else begin
            chk({name, "_busy_cycles"}, 32'(n), special ? 32'd2 : 32'd34);
            chk({name, "_done_seen"}, 32'(sb_q.size()), 32'd0);
            while (sb_q.size() != 0) void'(sb_q.pop_front());
            last_result = exp;
            last_rd     = rd;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        total       = 0;
        bad         = 0;
        cyc         = 0;
        prev_done   = 1'b0;
        last_result = '0;
        last_rd     = '0;
        rst_n       = 1'b0;
        start       = 1'b0;
        flush       = 1'b0;
        op          = OP_MUL;
        operand_a   = '0;
        operand_b   = '0;
        rd_addr_in  = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd", 32'(rd_addr_out), 32'd0);
        rst_n = 1'b1;

        // Multiplies
        issue(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 0, 0, "mul_7x-3");
        issue(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0, 0, 0, "mulh_min");
        issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0, 0, 0, "mulhu_max");
        issue(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 1'b0, 0, 0, "mulhsu_-1x2");
        issue(OP_MULH,   32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 1'b0, 0, 0, "mulh_-7x2");
        issue(OP_MUL,    32'h0001_0000,  32'h0001_0000, 5'd11, 32'h0000_0000, 1'b0, 0, 0, "mul_2p32");
        issue(OP_MULHU,  32'h0001_0000,  32'h0001_0000, 5'd12, 32'h0000_0001, 1'b0, 0, 0, "mulhu_2p32");

        // Divides
        issue(OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFD, 1'b0, 0, 0, "div_-7/2");
        issue(OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd14, 32'hFFFF_FFFF, 1'b0, 0, 0, "rem_-7/2");
        issue(OP_DIVU,   32'd100,        32'd7,         5'd15, 32'd14,        1'b0, 0, 0, "divu_100/7");
        issue(OP_REMU,   32'd100,        32'd7,         5'd16, 32'd2,         1'b0, 0, 0, "remu_100/7");
        issue(OP_DIV,    32'd7,          32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 1'b0, 0, 0, "div_7/-2");
        issue(OP_REM,    32'd7,          32'hFFFF_FFFE, 5'd18, 32'd1,         1'b0, 0, 0, "rem_7/-2");
        issue(OP_DIVU,   32'hFFFF_FFFF,  32'hFFFF_FFFE, 5'd19, 32'd1,         1'b0, 0, 0, "divu_big");
        issue(OP_REMU,   32'hFFFF_FFFF,  32'hFFFF_FFFE, 5'd20, 32'd1,         1'b0, 0, 0, "remu_big");

        // Special cases resolved at acceptance
        issue(OP_DIVU,   32'd5,          32'd0,         5'd21, 32'hFFFF_FFFF, 1'b1, 0, 0, "divu_by0");
        issue(OP_REMU,   32'd5,          32'd0,         5'd22, 32'd5,         1'b1, 0, 0, "remu_by0");
        issue(OP_DIV,    32'd7,          32'd0,         5'd23, 32'hFFFF_FFFF, 1'b1, 0, 0, "div_by0");
        issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd24, 32'h8000_0000, 1'b1, 0, 0, "div_ovf");
        issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd25, 32'd0,         1'b1, 0, 0, "rem_ovf");

        // Start pulse during CALC is ignored
        issue(OP_DIVU,   32'd100,        32'd7,         5'd26, 32'd14,        1'b0, 5, 0, "divu_poked");

        // Flush at busy cycle 10: no done, outputs hold
        issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd27, 32'd0,         1'b0, 0, 10, "flush");

        // Asynchronous reset between clock edges during CALC
        @(negedge clk);
        start      = 1'b1;
        op         = OP_MULHU;
        operand_a  = 32'hFFFF_FFFF;
        operand_b  = 32'hFFFF_FFFF;
        rd_addr_in = 5'd28;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_rd", 32'(rd_addr_out), 32'd0);
        last_result = '0;
        last_rd     = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_MUL,    32'd6,          32'd7,         5'd3,  32'd42,        1'b0, 0, 0, "mul_after_rst");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
